// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the core's memory write port.
// Frame: MAGIC, base address (4 bytes LE), word count (4 bytes LE),
// count x data words (4 bytes LE each), optional checksum byte.
// Each received word is written through a valid/ready port. The core is held
// in reset until the whole image has been written (and verified).
// Build option: define PROG_LOADER_CSUM_EN to expect and verify the trailing
// checksum byte. Without it the loader completes after the last write and
// err_o is tied low.
module prog_loader #(
  parameter int unsigned XLEN  = 32,     // address/data width, must be 32
  parameter logic [7:0]  MAGIC = 8'hA5   // frame start byte
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rx_valid_i,
  input  logic [7:0]      rx_data_i,
  output logic            rx_ready_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ready_i,
  output logic            core_rstn_o,
  output logic            done_o,
  output logic            err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]      state;
  logic [1:0]      byte_cnt;    // byte position inside the current 4-byte field
  logic [XLEN-1:0] remaining;   // words still to be written

  logic rx_fire;
  logic wr_fire;
  logic last_byte;
  logic magic_hit;
  logic frame_start;

  assign rx_fire     = rx_valid_i && rx_ready_o;
  assign wr_fire     = mem_we_o && mem_ready_i;
  assign last_byte   = (byte_cnt == 2'd3);
  assign magic_hit   = rx_fire && (rx_data_i == MAGIC);
  // A new frame may only begin from an idle or finished state; a MAGIC value
  // seen mid-frame is plain payload.
  assign frame_start = magic_hit &&
                       ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  // Little-endian field assembly: each new byte enters at the top, so after
  // four bytes the first one received sits in bits [7:0].
  function automatic logic [XLEN-1:0] shift_in(input logic [XLEN-1:0] cur,
                                               input logic [7:0]      b);
    return {b, cur[XLEN-1:8]};
  endfunction

`ifdef PROG_LOADER_CSUM_EN
  logic [7:0] csum;   // running mod-256 sum of every byte after MAGIC

  function automatic logic [7:0] csum_add(input logic [7:0] acc,
                                          input logic [7:0] b);
    return acc + b;
  endfunction

  // Checksum accumulator: cleared by MAGIC, summed over header and payload.
  always_ff @(posedge clk_i) begin
    if (frame_start) begin
      csum <= 8'h00;
    end else if (rx_fire &&
                 ((state == S_ADDR) || (state == S_COUNT) || (state == S_DATA))) begin
      csum <= csum_add(csum, rx_data_i);
    end
  end

  // Sticky error flag: set by a checksum mismatch, cleared only by a new frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (frame_start) begin
      err_o <= 1'b0;
    end else if ((state == S_CSUM) && rx_fire && (rx_data_i != csum)) begin
      err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

  // Frame FSM with registered outputs; rx_ready_o is low only while a word
  // write is outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      byte_cnt    <= 2'd0;
      rx_ready_o  <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      core_rstn_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      rx_ready_o <= 1'b1;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (frame_start) begin
            state       <= S_ADDR;
            byte_cnt    <= 2'd0;
            done_o      <= 1'b0;
            core_rstn_o <= 1'b0;
          end
        end

        S_ADDR: begin
          if (rx_fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              // Word-align the base address as the final byte lands.
              mem_addr_o <= {rx_data_i, mem_addr_o[XLEN-1:10], 2'b00};
              state      <= S_COUNT;
            end else begin
              mem_addr_o <= shift_in(mem_addr_o, rx_data_i);
            end
          end
        end

        S_COUNT: begin
          if (rx_fire) begin
            byte_cnt  <= byte_cnt + 2'd1;
            remaining <= shift_in(remaining, rx_data_i);
            if (last_byte) begin
              if (shift_in(remaining, rx_data_i) == '0) begin
`ifdef PROG_LOADER_CSUM_EN
                state <= S_CSUM;
`else
                state       <= S_DONE;
                done_o      <= 1'b1;
                core_rstn_o <= 1'b1;
`endif
              end else begin
                state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_fire) begin
            byte_cnt    <= byte_cnt + 2'd1;
            mem_wdata_o <= shift_in(mem_wdata_o, rx_data_i);
            if (last_byte) begin
              state      <= S_WRITE;
              mem_we_o   <= 1'b1;
              rx_ready_o <= 1'b0;
            end
          end
        end

        S_WRITE: begin
          // Address and data stay frozen until the memory takes the word.
          if (wr_fire) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= mem_addr_o + XLEN'(4);
            remaining  <= remaining - XLEN'(1);
            if (remaining == XLEN'(1)) begin
`ifdef PROG_LOADER_CSUM_EN
              state <= S_CSUM;
`else
              state       <= S_DONE;
              done_o      <= 1'b1;
              core_rstn_o <= 1'b1;
`endif
            end else begin
              state <= S_DATA;
            end
          end else begin
            rx_ready_o <= 1'b0;
          end
        end

`ifdef PROG_LOADER_CSUM_EN
        S_CSUM: begin
          if (rx_fire) begin
            if (rx_data_i == csum) begin
              state       <= S_DONE;
              done_o      <= 1'b1;
              core_rstn_o <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end
        end
`else
        S_CSUM: begin
          state <= S_IDLE;
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed, table-driven bench for prog_loader, with
// hand-written sequences for backpressure, reload and mid-frame reset.
// Honours PROG_LOADER_CSUM_EN the same way the design does.
module tb_prog_loader;

`ifdef PROG_LOADER_CSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        core_rstn;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  prog_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .rx_ready_o  (rx_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ready_i (mem_ready),
    .core_rstn_o (core_rstn),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Record every completed memory write.
  always @(posedge clk) begin
    if (mem_we && mem_ready) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  typedef struct {
    logic [31:0]      base;
    int               nw;
    logic [2:0][31:0] w;
    bit               bad_cs;
    int               exp_n;
    logic [2:0][31:0] exp_a;
    logic [2:0][31:0] exp_d;
    logic             exp_done;
    logic             exp_err;
  } vec_t;

  vec_t vt[5];

  function automatic vec_t mk(input logic [31:0] base, input int nw,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input bit bad_cs,
                              input int exp_n,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2,
                              input logic exp_done, input logic exp_err);
    vec_t v;
    v.base     = base;
    v.nw       = nw;
    v.w        = {w2, w1, w0};
    v.bad_cs   = bad_cs;
    v.exp_n    = exp_n;
    v.exp_a    = {a2, a1, a0};
    v.exp_d    = {w2, w1, w0};
    v.exp_done = exp_done;
    v.exp_err  = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sum32(input logic [31:0] v);
    return v[7:0] + v[15:8] + v[23:16] + v[31:24];
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until an edge sees rx_ready high.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    while (!rx_ready && n < 200) begin
      n++;
      @(posedge clk);
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("FAIL rx_accept_timeout: byte %h, rx_ready=%b, expected 1", b, rx_ready);
    end
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input bit with_magic, input logic [31:0] base,
                            input int nw, input logic [2:0][31:0] w,
                            input bit bad_cs);
    logic [7:0]  cs;
    logic [31:0] cnt;
    cnt = 32'(nw);
    cs  = sum32(base) + sum32(cnt);
    if (with_magic) send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(base[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(cnt[8*i +: 8]);
    for (int k = 0; k < nw; k++) begin
      for (int i = 0; i < 4; i++) send_byte(w[k][8*i +: 8]);
      cs = cs + sum32(w[k]);
    end
    if (bad_cs) cs = cs - 8'd1;
    if (CS_EN) send_byte(cs);
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Stall the second word for three cycles and confirm the port holds still.
  task automatic stall_watch();
    int n;
    n = 0;
    @(negedge clk);
    while (!(mem_we && wr_addr_q.size() == 1) && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!(mem_we && wr_addr_q.size() == 1)) begin
      total++;
      bad++;
      $display("FAIL stall_arm_timeout: mem_we=%b writes=%0d, expected 1 and 1",
               mem_we, wr_addr_q.size());
    end else begin
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("stall_we",       32'(mem_we),            32'd1);
        check("stall_addr",     mem_addr,               32'h0000_0004);
        check("stall_data",     mem_wdata,              32'h2222_2222);
        check("stall_rx_ready", 32'(rx_ready),          32'd0);
        check("stall_writes",   32'(wr_addr_q.size()),  32'd1);
      end
      mem_ready = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    mem_ready = 1'b1;

    vt[0] = mk(32'h0000_1000, 1, 32'h00A0_0513, 32'h0, 32'h0, 1'b0,
               1, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1'b0);
    vt[1] = mk(32'h0000_1000, 1, 32'h00A0_0513, 32'h0, 32'h0, 1'b1,
               1, 32'h0000_1000, 32'h0, 32'h0, !CS_EN, CS_EN);
    vt[2] = mk(32'h0000_2000, 2, 32'h1122_3344, 32'hAABB_CCDD, 32'h0, 1'b0,
               2, 32'h0000_2000, 32'h0000_2004, 32'h0, 1'b1, 1'b0);
    vt[3] = mk(32'hFFFF_FFFC, 2, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0, 1'b0,
               2, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0, 1'b1, 1'b0);
    vt[4] = mk(32'h0000_3003, 3, 32'hCAFE_BABE, 32'h0102_0304, 32'h8070_6050, 1'b0,
               3, 32'h0000_3000, 32'h0000_3004, 32'h0000_3008, 1'b1, 1'b0);

    // Reset values
    wait_cycles(3);
    check("rst_rx_ready",  32'(rx_ready),  32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_core_rstn", 32'(core_rstn), 32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    rst = 1'b0;
    wait_cycles(1);
    check("post_rst_rx_ready", 32'(rx_ready), 32'd1);

    // Garbage before MAGIC, then a zero-count frame
    clear_writes();
    send_byte(8'h00);
    send_byte(8'hFF);
    check("garbage_done", 32'(done), 32'd0);
    send_frame(1'b1, 32'h0000_0100, 0, '0, 1'b0);
    wait_cycles(3);
    check("zero_writes",    32'(wr_addr_q.size()), 32'd0);
    check("zero_done",      32'(done),             32'd1);
    check("zero_core_rstn", 32'(core_rstn),        32'd1);
    check("zero_err",       32'(err),              32'd0);

    // MAGIC while DONE restarts loading on the very next cycle
    clear_writes();
    send_byte(8'hA5);
    check("reload_done",      32'(done),      32'd0);
    check("reload_core_rstn", 32'(core_rstn), 32'd0);
    send_frame(1'b0, 32'h0000_0500, 1, {32'h0, 32'h0, 32'h1234_5678}, 1'b0);
    wait_cycles(3);
    check("reload_writes", 32'(wr_addr_q.size()), 32'd1);
    check("reload_addr",   (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hxxxx_xxxx, 32'h0000_0500);
    check("reload_data",   (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxx_xxxx, 32'h1234_5678);
    check("reload_done2",  32'(done), 32'd1);

    // Table of single frames
    for (int v = 0; v < 5; v++) begin
      clear_writes();
      send_frame(1'b1, vt[v].base, vt[v].nw, vt[v].w, vt[v].bad_cs);
      wait_cycles(3);
      check($sformatf("v%0d_writes", v), 32'(wr_addr_q.size()), 32'(vt[v].exp_n));
      for (int j = 0; j < vt[v].exp_n; j++) begin
        check($sformatf("v%0d_addr%0d", v, j),
              (j < wr_addr_q.size()) ? wr_addr_q[j] : 32'hxxxx_xxxx, vt[v].exp_a[j]);
        check($sformatf("v%0d_data%0d", v, j),
              (j < wr_data_q.size()) ? wr_data_q[j] : 32'hxxxx_xxxx, vt[v].exp_d[j]);
      end
      check($sformatf("v%0d_done", v),      32'(done),      32'(vt[v].exp_done));
      check($sformatf("v%0d_err", v),       32'(err),       32'(vt[v].exp_err));
      check($sformatf("v%0d_core_rstn", v), 32'(core_rstn), 32'(vt[v].exp_done));
    end

    // Three words, second one stalled by the memory
    clear_writes();
    fork
      send_frame(1'b1, 32'h0000_0000, 3,
                 {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b0);
      stall_watch();
    join
    wait_cycles(3);
    check("bp_writes", 32'(wr_addr_q.size()), 32'd3);
    check("bp_addr0", (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hxxxx_xxxx, 32'h0000_0000);
    check("bp_addr1", (wr_addr_q.size() > 1) ? wr_addr_q[1] : 32'hxxxx_xxxx, 32'h0000_0004);
    check("bp_addr2", (wr_addr_q.size() > 2) ? wr_addr_q[2] : 32'hxxxx_xxxx, 32'h0000_0008);
    check("bp_data0", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxx_xxxx, 32'h1111_1111);
    check("bp_data1", (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hxxxx_xxxx, 32'h2222_2222);
    check("bp_data2", (wr_data_q.size() > 2) ? wr_data_q[2] : 32'hxxxx_xxxx, 32'h3333_3333);
    check("bp_done",  32'(done), 32'd1);

    // Reset after the second data byte of a frame
    clear_writes();
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    wait_cycles(1);
    check("mid_rst_rx_ready",  32'(rx_ready),  32'd0);
    check("mid_rst_mem_we",    32'(mem_we),    32'd0);
    check("mid_rst_mem_addr",  mem_addr,       32'd0);
    check("mid_rst_mem_wdata", mem_wdata,      32'd0);
    check("mid_rst_core_rstn", 32'(core_rstn), 32'd0);
    check("mid_rst_done",      32'(done),      32'd0);
    check("mid_rst_err",       32'(err),       32'd0);
    rst = 1'b0;
    wait_cycles(2);
    check("mid_rst_rx_ready1", 32'(rx_ready), 32'd1);
    check("mid_rst_writes",    32'(wr_addr_q.size()), 32'd0);
    send_frame(1'b1, 32'h0000_4000, 1, {32'h0, 32'h0, 32'h5566_7788}, 1'b0);
    wait_cycles(3);
    check("after_rst_writes", 32'(wr_addr_q.size()), 32'd1);
    check("after_rst_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hxxxx_xxxx, 32'h0000_4000);
    check("after_rst_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxx_xxxx, 32'h5566_7788);
    check("after_rst_done", 32'(done), 32'd1);
    check("after_rst_core_rstn", 32'(core_rstn), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
